uart_word_tx_queue: RTL and testbench

//  Buffers 32-bit words issued by the EX-stage "send" instruction (RegtoUART & distinct) and streams

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_word_tx_queue_if.sv | 24 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_word_tx_queue.sv | 105 ++++++++++
 tb/tb_uart_word_tx_queue.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART word transmit path.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;
  localparam int unsigned WORD_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT
  } tx_state_t;

endpackage

// File: rtl/uart_word_tx_queue_if.sv
// Word push / sender byte handshake between the EX stage, the queue and the UART sender.
interface uart_word_tx_queue_if;
  import uart_pkg::*;

  logic [WORD_W-1:0]      word_in;
  logic                   word_valid;
  logic                   sender_ready;
  logic [UART_BYTE_W-1:0] sender_data;
  logic                   sender_enable;
  logic                   full;
  logic                   empty;
  logic                   overflow;

  modport master (
    output word_in, word_valid, sender_ready,
    input  sender_data, sender_enable, full, empty, overflow
  );

  modport slave (
    input  word_in, word_valid, sender_ready,
    output sender_data, sender_enable, full, empty, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock word FIFO: RAM, wrapping pointers, occupancy count and its next-cycle value.
module sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data_c,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_nxt_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  assign rd_data_c = mem[rd_ptr];

  // Caller guarantees push only below DEPTH and pop only when non-empty.
  always_comb begin
    count_nxt_c = count;
    case ({push, pop})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/uart_word_tx_queue.sv
// Queues EX-stage send words and streams them LSB-first, byte by byte, to the UART sender.
module uart_word_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned SEND_BYTES  = 1,
  parameter int unsigned FULL_MARGIN = 4
) (
  input logic                 CLK,
  input logic                 reset,
  uart_word_tx_queue_if.slave bus
);

  localparam int unsigned     DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned     CNT_W      = DEPTH_LOG2 + 1;
  localparam int unsigned     FULL_LEVEL = DEPTH - FULL_MARGIN;
  localparam int unsigned     IDX_W      = 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEND_BYTES - 1);

  tx_state_t         state;
  logic [IDX_W-1:0]  byte_idx;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] head_c;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt_c;
  logic              push_c;
  logic              pop_c;
  logic              empty_nxt_c;

  assign push_c      = bus.word_valid && (count < CNT_W'(DEPTH));
  assign pop_c       = (state == WAIT) && bus.sender_ready && (byte_idx == LAST_IDX);
  assign empty_nxt_c = (count_nxt_c == '0) && ((state == IDLE) || pop_c);

  sync_fifo #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK         (CLK),
    .reset       (reset),
    .push        (push_c),
    .pop         (pop_c),
    .wr_data     (bus.word_in),
    .rd_data_c   (head_c),
    .count       (count),
    .count_nxt_c (count_nxt_c)
  );

  // Status flags track next-cycle occupancy so the core stalls with IF..EX slack left.
  always_ff @(posedge CLK) begin
    if (reset) begin
      bus.full     <= 1'b0;
      bus.empty    <= 1'b1;
      bus.overflow <= 1'b0;
    end else begin
      bus.full  <= (count_nxt_c >= CNT_W'(FULL_LEVEL));
      bus.empty <= empty_nxt_c;
      if (bus.word_valid && (count == CNT_W'(DEPTH))) begin
        bus.overflow <= 1'b1;
      end
    end
  end

  // SETTLE skips one ready sample because the sender drops ready a cycle after the pulse.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state             <= IDLE;
      byte_idx          <= '0;
      shift             <= '0;
      bus.sender_data   <= '0;
      bus.sender_enable <= 1'b0;
    end else begin
      bus.sender_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state    <= ISSUE;
            byte_idx <= '0;
            shift    <= head_c;
          end
        end
        ISSUE: begin
          if (bus.sender_ready) begin
            bus.sender_data   <= shift[UART_BYTE_W-1:0];
            bus.sender_enable <= 1'b1;
            state             <= SETTLE;
          end
        end
        SETTLE: state <= WAIT;
        WAIT: begin
          if (bus.sender_ready) begin
            if (byte_idx == LAST_IDX) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              shift    <= shift >> UART_BYTE_W;
              state    <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx_queue.sv
// Directed bench for uart_word_tx_queue: one-byte and four-byte instances driven from vectors and sequences.
module tb_uart_word_tx_queue;
  import uart_pkg::*;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  uart_word_tx_queue_if bus1 ();
  uart_word_tx_queue_if bus4 ();

  uart_word_tx_queue #(.DEPTH_LOG2(4), .SEND_BYTES(1), .FULL_MARGIN(4)) u_dut1 (
    .CLK(CLK), .reset(reset), .bus(bus1.slave));
  uart_word_tx_queue #(.DEPTH_LOG2(4), .SEND_BYTES(4), .FULL_MARGIN(4)) u_dut4 (
    .CLK(CLK), .reset(reset), .bus(bus4.slave));

  typedef struct {
    logic        valid;
    logic [31:0] word;
    logic        ready;
    logic        exp_en;
    logic [7:0]  exp_data;
    logic        exp_empty;
  } vec_t;

  vec_t       tbl [23];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last1 = -100;
  int         last4 = -100;
  logic [7:0] got1 [$];
  logic [7:0] exp1 [$];
  logic [7:0] got4 [$];
  logic [7:0] exp4 [$];
  int         pcyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock, sampled 1ns after the edge; records pulses and enforces the 3-cycle minimum spacing.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (bus1.sender_enable) begin
      check("gap1", 32'(cyc - last1 >= 3), 32'd1);
      last1 = cyc;
      got1.push_back(bus1.sender_data);
    end
    if (bus4.sender_enable) begin
      check("gap4", 32'(cyc - last4 >= 3), 32'd1);
      last4 = cyc;
      pcyc.push_back(cyc);
      got4.push_back(bus4.sender_data);
    end
  endtask

  task automatic compare4(input string name);
    logic [7:0] b;
    while (got4.size() > 0) begin
      b = got4.pop_front();
      check({name, "_have"}, 32'(exp4.size() != 0), 32'd1);
      if (exp4.size() != 0) check(name, 32'(b), 32'(exp4.pop_front()));
    end
  endtask

  initial begin
    logic [31:0] w;
    int lag;
    int busy;

    tbl[0]  = '{1'b1, 32'h11223344, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h44, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h44, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h44, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h44, 1'b1};
    tbl[6]  = '{1'b1, 32'hAABBCC01, 1'b1, 1'b0, 8'h44, 1'b0};
    tbl[7]  = '{1'b1, 32'h00000055, 1'b1, 1'b0, 8'h44, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h01, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h01, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h01, 1'b0};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h01, 1'b0};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h55, 1'b0};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h55, 1'b0};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h55, 1'b1};
    tbl[15] = '{1'b1, 32'h00000099, 1'b1, 1'b0, 8'h55, 1'b0};
    tbl[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h55, 1'b0};
    tbl[17] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'h55, 1'b0};
    tbl[18] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'h55, 1'b0};
    tbl[19] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h99, 1'b0};
    tbl[20] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'h99, 1'b0};
    tbl[21] = '{1'b0, 32'h0,        1'b0, 1'b0, 8'h99, 1'b0};
    tbl[22] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h99, 1'b1};

    reset = 1'b1;
    bus1.word_valid = 1'b0; bus1.word_in = '0; bus1.sender_ready = 1'b1;
    bus4.word_valid = 1'b0; bus4.word_in = '0; bus4.sender_ready = 1'b1;
    repeat (3) tick();
    check("rst_en1",    32'(bus1.sender_enable), 32'd0);
    check("rst_data1",  32'(bus1.sender_data),   32'd0);
    check("rst_full1",  32'(bus1.full),          32'd0);
    check("rst_empty1", 32'(bus1.empty),         32'd1);
    check("rst_ovf1",   32'(bus1.overflow),      32'd0);
    check("rst_en4",    32'(bus4.sender_enable), 32'd0);
    check("rst_empty4", 32'(bus4.empty),         32'd1);
    reset = 1'b0;

    // Single-byte instance: latency, back-to-back words, ready stalls in ISSUE and WAIT.
    for (int r = 0; r < 23; r++) begin
      bus1.word_valid   = tbl[r].valid;
      bus1.word_in      = tbl[r].word;
      bus1.sender_ready = tbl[r].ready;
      tick();
      check($sformatf("t1_en[%0d]", r),    32'(bus1.sender_enable), 32'(tbl[r].exp_en));
      check($sformatf("t1_data[%0d]", r),  32'(bus1.sender_data),   32'(tbl[r].exp_data));
      check($sformatf("t1_empty[%0d]", r), 32'(bus1.empty),         32'(tbl[r].exp_empty));
      check($sformatf("t1_full[%0d]", r),  32'(bus1.full),          32'd0);
    end
    bus1.word_valid = 1'b0;
    bus1.sender_ready = 1'b1;
    got1.delete();

    // Push lands in the pop cycle each time; 20 words wrap the 16-entry pointers.
    for (int c = 0; c < 86; c++) begin
      bus1.word_valid = (c % 4 == 0) && (c < 80);
      w = {8'hC0, 8'(c / 4), 8'hDE, 8'(c / 4 + 48)};
      bus1.word_in = w;
      if (bus1.word_valid) exp1.push_back(w[7:0]);
      tick();
      check($sformatf("t4_empty[%0d]", c), 32'(bus1.empty), 32'(c >= 80));
    end
    bus1.word_valid = 1'b0;
    check("t4_npulse", 32'(got1.size()), 32'd20);
    for (int i = 0; i < got1.size() && i < exp1.size(); i++)
      check($sformatf("t4_byte[%0d]", i), 32'(got1[i]), 32'(exp1[i]));

    // Four-byte word against a sender that goes busy for 10 cycles after each pulse.
    bus4.sender_ready = 1'b1;
    bus4.word_valid = 1'b1;
    bus4.word_in = 32'hA1B2C3D4;
    got4.delete(); pcyc.delete();
    tick();
    bus4.word_valid = 1'b0;
    lag = 0; busy = 0;
    for (int c = 0; c < 80; c++) begin
      bus4.sender_ready = (busy == 0);
      tick();
      if (bus4.sender_enable) lag = 1;
      else if (lag != 0) begin lag = 0; busy = 10; end
      else if (busy > 0) busy--;
    end
    exp4 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    check("t2_npulse", 32'(got4.size()), 32'd4);
    for (int i = 1; i < pcyc.size(); i++)
      check($sformatf("t2_gap[%0d]", i), 32'(pcyc[i] - pcyc[i-1]), 32'd13);
    compare4("t2_byte");
    check("t2_empty", 32'(bus4.empty), 32'd1);

    // Stalled sender: full after the 12th push, 16 accepted, 17th dropped and sticky overflow.
    bus4.sender_ready = 1'b0;
    got4.delete(); exp4.delete();
    for (int i = 0; i < 17; i++) begin
      bus4.word_valid = 1'b1;
      w = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      bus4.word_in = w;
      if (i < 16) begin
        exp4.push_back(w[7:0]);   exp4.push_back(w[15:8]);
        exp4.push_back(w[23:16]); exp4.push_back(w[31:24]);
      end
      tick();
      check($sformatf("t3_full[%0d]", i), 32'(bus4.full),     32'(i >= 11));
      check($sformatf("t3_ovf[%0d]", i),  32'(bus4.overflow), 32'(i == 16));
    end
    bus4.word_valid = 1'b0;
    repeat (3) tick();
    check("t3_ovf_sticky", 32'(bus4.overflow), 32'd1);
    check("t3_nopulse",    32'(got4.size()),   32'd0);
    bus4.sender_ready = 1'b1;
    repeat (400) tick();
    check("t3_npulse", 32'(got4.size()), 32'd64);
    compare4("t3_byte");
    check("t3_empty",     32'(bus4.empty),    32'd1);
    check("t3_full_end",  32'(bus4.full),     32'd0);
    check("t3_ovf_end",   32'(bus4.overflow), 32'd1);

    // Reset while byte 2 of 4 is in SETTLE with three words queued.
    got4.delete(); exp4.delete();
    for (int i = 0; i < 3; i++) begin
      bus4.word_valid = 1'b1;
      bus4.word_in = 32'h5A5A0000 + 32'(i);
      tick();
    end
    bus4.word_valid = 1'b0;
    for (int c = 0; c < 20 && got4.size() < 2; c++) tick();
    check("t5_reach", 32'(got4.size()), 32'd2);
    reset = 1'b1;
    tick();
    check("t5_en",    32'(bus4.sender_enable), 32'd0);
    check("t5_empty", 32'(bus4.empty),         32'd1);
    check("t5_full",  32'(bus4.full),          32'd0);
    check("t5_ovf",   32'(bus4.overflow),      32'd0);
    reset = 1'b0;
    got4.delete();
    repeat (40) tick();
    check("t5_quiet",  32'(got4.size()), 32'd0);
    check("t5_empty2", 32'(bus4.empty),  32'd1);

    // Random pushes (held off by full, as the core would) and random sender ready.
    got4.delete(); exp4.delete();
    for (int c = 0; c < 10000; c++) begin
      bus4.sender_ready = 1'($urandom_range(0, 1));
      bus4.word_valid   = !bus4.full && ($urandom_range(0, 99) < 12);
      w = $urandom;
      bus4.word_in = w;
      if (bus4.word_valid) begin
        exp4.push_back(w[7:0]);   exp4.push_back(w[15:8]);
        exp4.push_back(w[23:16]); exp4.push_back(w[31:24]);
      end
      tick();
      compare4("t6_byte");
    end
    bus4.word_valid = 1'b0;
    bus4.sender_ready = 1'b1;
    for (int c = 0; c < 600 && exp4.size() > 0; c++) begin
      tick();
      compare4("t6_byte");
    end
    repeat (4) tick();
    compare4("t6_byte");
    check("t6_drained", 32'(exp4.size()),   32'd0);
    check("t6_empty",   32'(bus4.empty),    32'd1);
    check("t6_ovf",     32'(bus4.overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
